ex_forward_scoreboard: RTL and testbench



---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_src_select.sv | 52 +++++
 rtl/ex_forward_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_ex_forward_scoreboard.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and constants for the EX-stage forwarding scoreboard
package fwd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } fwd_state_e;

    localparam logic [6:0] OP_MEMORY_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_MEMORY_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM      = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG      = 7'b0110011;

    localparam int REG_X0 = 0;

    // Wide enough for LOAD_LAT up to 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - priority operand match for one source across forwarding stages and the hold entry
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 2
) (
    input  logic [REG_ADDR_W-1:0]         rs,
    input  logic                          rs_used,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_regwrite,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic                          hold_valid,
    input  logic [REG_ADDR_W-1:0]         hold_rd,
    input  logic [XLEN-1:0]               hold_data,
    output logic [XLEN-1:0]               src_data,
    output logic                          src_fwd_en,
    output logic                          stage0_hit
);

    logic               rs_live;
    logic [NUM_FWD-1:0] stage_match;

    assign rs_live    = rs_used && (rs != REG_ADDR_W'(REG_X0));
    assign stage0_hit = stage_match[0];

    always_comb begin
        stage_match = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            stage_match[k] = rs_live && fwd_regwrite[k] &&
                             (fwd_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs);
        end
    end

    // Hold entry is the lowest priority; walking oldest to youngest lets the youngest hit win.
    always_comb begin
        src_data   = '0;
        src_fwd_en = 1'b0;
        if (rs_live && hold_valid && (hold_rd == rs)) begin
            src_data   = hold_data;
            src_fwd_en = 1'b1;
        end
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (stage_match[k]) begin
                src_data   = fwd_data[k*XLEN +: XLEN];
                src_fwd_en = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_forward_scoreboard.sv
// rtl/ex_forward_scoreboard.sv - EX operand forwarding with write-back hold and load-use stall FSM (option: FWD_PERF_CNT_EN)
module ex_forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          ex_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
    input  logic [NUM_SRC-1:0]            ex_rs_used,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]            fwd_regwrite,
    input  logic [NUM_FWD-1:0]            fwd_memtoreg,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    output logic [NUM_SRC*XLEN-1:0]       ex_src_data,
    output logic [NUM_SRC-1:0]            ex_src_fwd_en,
    output logic                          ex_stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_stall_cycles,
    output logic [31:0]                   perf_fwd_events
`endif
);

    localparam int OLD = NUM_FWD - 1;

    fwd_state_e             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   hold_valid;
    logic [REG_ADDR_W-1:0]  hold_rd;
    logic [XLEN-1:0]        hold_data;
    logic [NUM_SRC*XLEN-1:0] src_data_raw;
    logic [NUM_SRC-1:0]     src_fwd_raw;
    logic [NUM_SRC-1:0]     src_hit0;
    logic                   detect;
    logic                   older_memtoreg_unused;

    // Loads in older stages already have their data; their memtoreg never stalls.
    assign older_memtoreg_unused = |fwd_memtoreg[NUM_FWD-1:1];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_select #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_FWD    (NUM_FWD)
        ) u_sel (
            .rs           (ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .rs_used      (ex_rs_used[i]),
            .fwd_rd       (fwd_rd),
            .fwd_regwrite (fwd_regwrite),
            .fwd_data     (fwd_data),
            .hold_valid   (hold_valid),
            .hold_rd      (hold_rd),
            .hold_data    (hold_data),
            .src_data     (src_data_raw[i*XLEN +: XLEN]),
            .src_fwd_en   (src_fwd_raw[i]),
            .stage0_hit   (src_hit0[i])
        );
    end

    // Outputs are forced to their reset values while rst_n is low, independent of inputs.
    assign ex_src_data   = src_data_raw & {(NUM_SRC*XLEN){rst_n}};
    assign ex_src_fwd_en = src_fwd_raw & {NUM_SRC{rst_n}};
    assign detect        = rst_n && ex_valid && fwd_memtoreg[0] && (|src_hit0);

    // Write-back hold: covers the register file's write-then-read gap; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
        end else begin
            hold_valid <= fwd_regwrite[OLD] &&
                          (fwd_rd[OLD*REG_ADDR_W +: REG_ADDR_W] != REG_ADDR_W'(REG_X0));
            hold_rd    <= fwd_rd[OLD*REG_ADDR_W +: REG_ADDR_W];
            hold_data  <= fwd_data[OLD*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Stall spans LOAD_LAT cycles: the detecting IDLE cycle plus LOAD_LAT-1 WAIT cycles.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ex_stall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (detect) begin
                    ex_stall = 1'b1;
                    if (LOAD_LAT == 1) begin
                        state_n = ST_RELEASE;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            ST_WAIT: begin
                ex_stall = 1'b1;
                if (cnt <= CNT_W'(1)) begin
                    state_n = ST_RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
                if (detect) begin
                    if (LOAD_LAT == 1) begin
                        state_n = ST_RELEASE;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        if (flush) begin
            ex_stall = 1'b0;
            state_n  = ST_IDLE;
            cnt_n    = '0;
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_fwd_events   <= '0;
        end else begin
            if (ex_stall && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if ((|ex_src_fwd_en) && (perf_fwd_events != 32'hFFFF_FFFF)) begin
                perf_fwd_events <= perf_fwd_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_forward_scoreboard.sv
// tb/tb_ex_forward_scoreboard.sv - directed self-checking bench for ex_forward_scoreboard (LOAD_LAT=3)
module tb_ex_forward_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int NF   = 2;
    localparam int LL   = 3;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             ex_valid;
    logic [NS*AW-1:0] ex_rs;
    logic [NS-1:0]    ex_rs_used;
    logic [NF*AW-1:0] fwd_rd;
    logic [NF-1:0]    fwd_regwrite;
    logic [NF-1:0]    fwd_memtoreg;
    logic [NF*XLEN-1:0] fwd_data;
    logic [NS*XLEN-1:0] ex_src_data;
    logic [NS-1:0]    ex_src_fwd_en;
    logic             ex_stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]      perf_stall_cycles;
    logic [31:0]      perf_fwd_events;
`endif

    int checks = 0;
    int errors = 0;

    ex_forward_scoreboard #(
        .XLEN(XLEN), .REG_ADDR_W(AW), .NUM_SRC(NS), .NUM_FWD(NF), .LOAD_LAT(LL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_rs         (ex_rs),
        .ex_rs_used    (ex_rs_used),
        .fwd_rd        (fwd_rd),
        .fwd_regwrite  (fwd_regwrite),
        .fwd_memtoreg  (fwd_memtoreg),
        .fwd_data      (fwd_data),
        .ex_src_data   (ex_src_data),
        .ex_src_fwd_en (ex_src_fwd_en),
        .ex_stall      (ex_stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fwd_events   (perf_fwd_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        flush        = 1'b0;
        ex_valid     = 1'b0;
        ex_rs        = '0;
        ex_rs_used   = '0;
        fwd_rd       = '0;
        fwd_regwrite = '0;
        fwd_memtoreg = '0;
        fwd_data     = '0;
    endtask

    task automatic set_stage(input int k, input logic [AW-1:0] rd, input logic we,
                             input logic mtr, input logic [XLEN-1:0] d);
        fwd_rd[k*AW +: AW]     = rd;
        fwd_regwrite[k]        = we;
        fwd_memtoreg[k]        = mtr;
        fwd_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] rs, input logic used);
        ex_rs[i*AW +: AW] = rs;
        ex_rs_used[i]     = used;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", ex_stall); end
        checks++; if (ex_src_fwd_en !== 2'b00) begin errors++; $display("FAIL reset_fwd_en: got %b expected 00", ex_src_fwd_en); end
        checks++; if (ex_src_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", ex_src_data); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall_cycles); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(0, 5'd5, 1'b1, 1'b0, 32'h0000_AAAA);
        set_stage(1, 5'd5, 1'b1, 1'b0, 32'h0000_BBBB);
        set_src(0, 5'd5, 1'b1);
        set_src(1, 5'd5, 1'b0);
        @(negedge clk);
        checks++; if (ex_src_data[31:0] !== 32'h0000_AAAA) begin errors++; $display("FAIL prio_youngest_data: got %h expected 0000aaaa", ex_src_data[31:0]); end
        checks++; if (ex_src_fwd_en[0] !== 1'b1) begin errors++; $display("FAIL prio_en0: got %b expected 1", ex_src_fwd_en[0]); end
        checks++; if (ex_src_fwd_en[1] !== 1'b0) begin errors++; $display("FAIL prio_unused_en1: got %b expected 0", ex_src_fwd_en[1]); end
        checks++; if (ex_src_data[63:32] !== 32'h0) begin errors++; $display("FAIL prio_unused_data1: got %h expected 0", ex_src_data[63:32]); end
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL prio_no_stall: got %b expected 0", ex_stall); end
        next_cycle();
        set_stage(0, 5'd5, 1'b0, 1'b0, 32'h0000_AAAA);
        set_stage(1, 5'd5, 1'b1, 1'b0, 32'h0000_CCCC);
        @(negedge clk);
        checks++; if (ex_src_data[31:0] !== 32'h0000_CCCC) begin errors++; $display("FAIL prio_older_data: got %h expected 0000cccc", ex_src_data[31:0]); end
    endtask

    task automatic test_x0();
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(0, 5'd0, 1'b1, 1'b0, 32'h0000_1234);
        set_src(0, 5'd0, 1'b1);
        set_src(1, 5'd5, 1'b1);
        @(negedge clk);
        checks++; if (ex_src_fwd_en[0] !== 1'b0) begin errors++; $display("FAIL x0_en: got %b expected 0", ex_src_fwd_en[0]); end
        checks++; if (ex_src_data[31:0] !== 32'h0) begin errors++; $display("FAIL x0_data: got %h expected 0", ex_src_data[31:0]); end
        checks++; if (ex_src_fwd_en[1] !== 1'b1) begin errors++; $display("FAIL hold_prev_en: got %b expected 1", ex_src_fwd_en[1]); end
        checks++; if (ex_src_data[63:32] !== 32'h0000_CCCC) begin errors++; $display("FAIL hold_prev_data: got %h expected 0000cccc", ex_src_data[63:32]); end
    endtask

    task automatic test_hold();
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(1, 5'd9, 1'b1, 1'b0, 32'h0000_0055);
        set_src(0, 5'd9, 1'b1);
        @(negedge clk);
        checks++; if (ex_src_data[31:0] !== 32'h0000_0055) begin errors++; $display("FAIL hold_stage1_data: got %h expected 00000055", ex_src_data[31:0]); end
        next_cycle();
        set_stage(1, 5'd0, 1'b0, 1'b0, 32'h0);
        set_src(1, 5'd9, 1'b0);
        @(negedge clk);
        checks++; if (ex_src_fwd_en[0] !== 1'b1) begin errors++; $display("FAIL hold_en: got %b expected 1", ex_src_fwd_en[0]); end
        checks++; if (ex_src_data[31:0] !== 32'h0000_0055) begin errors++; $display("FAIL hold_data: got %h expected 00000055", ex_src_data[31:0]); end
        checks++; if (ex_src_fwd_en[1] !== 1'b0) begin errors++; $display("FAIL hold_unused_src: got %b expected 0", ex_src_fwd_en[1]); end
        next_cycle();
        @(negedge clk);
        checks++; if (ex_src_fwd_en[0] !== 1'b0) begin errors++; $display("FAIL hold_expired: got %b expected 0", ex_src_fwd_en[0]); end
    endtask

    task automatic test_load_use();
        int stalls;
        stalls = 0;
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(0, 5'd7, 1'b1, 1'b1, 32'h0000_DEAD);
        set_src(1, 5'd7, 1'b1);
        @(negedge clk);
        if (ex_stall === 1'b1) stalls++;
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c1: got %b expected 1", ex_stall); end
        checks++; if (ex_src_fwd_en[1] !== 1'b1) begin errors++; $display("FAIL lu_fwd_during_stall: got %b expected 1", ex_src_fwd_en[1]); end
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            @(negedge clk);
            if (ex_stall === 1'b1) stalls++;
            checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL lu_stall_c%0d: got %b expected 1", c, ex_stall); end
        end
        next_cycle();
        set_stage(0, 5'd0, 1'b0, 1'b0, 32'h0);
        set_stage(1, 5'd7, 1'b1, 1'b1, 32'h0000_0077);
        @(negedge clk);
        if (ex_stall === 1'b1) stalls++;
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL lu_release_stall: got %b expected 0", ex_stall); end
        checks++; if (ex_src_fwd_en[1] !== 1'b1) begin errors++; $display("FAIL lu_release_en: got %b expected 1", ex_src_fwd_en[1]); end
        checks++; if (ex_src_data[63:32] !== 32'h0000_0077) begin errors++; $display("FAIL lu_release_data: got %h expected 00000077", ex_src_data[63:32]); end
        checks++; if (stalls != LL) begin errors++; $display("FAIL lu_stall_len: got %0d expected %0d", stalls, LL); end
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(1, 5'd3, 1'b1, 1'b1, 32'h0000_0033);
        set_src(0, 5'd3, 1'b1);
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL old_load_no_stall: got %b expected 0", ex_stall); end
        checks++; if (ex_src_data[31:0] !== 32'h0000_0033) begin errors++; $display("FAIL old_load_data: got %h expected 00000033", ex_src_data[31:0]); end
        next_cycle(); clear_inputs(); ex_valid = 1'b0;
        set_stage(0, 5'd4, 1'b1, 1'b1, 32'h0000_0044);
        set_src(0, 5'd4, 1'b1);
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL invalid_no_stall: got %b expected 0", ex_stall); end
        checks++; if (ex_src_data[31:0] !== 32'h0000_0044) begin errors++; $display("FAIL invalid_fwd_data: got %h expected 00000044", ex_src_data[31:0]); end
    endtask

    task automatic test_flush();
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(0, 5'd7, 1'b1, 1'b1, 32'h0000_DEAD);
        set_src(1, 5'd7, 1'b1);
        @(negedge clk);
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL fl_stall_c1: got %b expected 1", ex_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL fl_stall_c2: got %b expected 1", ex_stall); end
        next_cycle(); flush = 1'b1;
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL fl_flush_cycle: got %b expected 0", ex_stall); end
        next_cycle(); flush = 1'b0;
        @(negedge clk);
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL fl_idle_redetect: got %b expected 1", ex_stall); end
        next_cycle(); clear_inputs(); flush = 1'b1;
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL fl_second_flush: got %b expected 0", ex_stall); end
        next_cycle(); flush = 1'b0;
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL fl_idle_quiet: got %b expected 0", ex_stall); end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle(); clear_inputs(); ex_valid = 1'b1;
        set_stage(0, 5'd7, 1'b1, 1'b1, 32'h0000_DEAD);
        set_src(1, 5'd7, 1'b1);
        @(negedge clk);
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_c1: got %b expected 1", ex_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_c2: got %b expected 1", ex_stall); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL rst_async_stall: got %b expected 0", ex_stall); end
        checks++; if (ex_src_fwd_en !== 2'b00) begin errors++; $display("FAIL rst_async_fwd_en: got %b expected 00", ex_src_fwd_en); end
`ifdef FWD_PERF_CNT_EN
        checks++; if (perf_stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_perf_stall: got %0d expected 0", perf_stall_cycles); end
        checks++; if (perf_fwd_events !== 32'd0) begin errors++; $display("FAIL rst_perf_fwd: got %0d expected 0", perf_fwd_events); end
`endif
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL rst_after_release: got %b expected 0", ex_stall); end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_priority();
        test_x0();
        test_hold();
        test_load_use();
        test_flush();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
